// File: rtl/seq_cg_ctrl.sv
// Sequencer and clock-gate controller: load an N-sample burst, run the enabled stages, then the output phase.
// Optional build macro SEQ_LAT_CNT_EN adds the lat_cnt latency counter output.
module seq_cg_ctrl #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cg_en,
  input  logic          in_valid,
  input  logic [2:0]    in_mode,
  output logic          load_en,
  output logic [IW-1:0] load_idx,
  output logic [2:0]    stage_en,
  output logic [IW-1:0] elem_idx,
  output logic          out_valid,
  output logic [3:0]    gate_en,
  output logic          busy,
`ifdef SEQ_LAT_CNT_EN
  output logic [15:0]   lat_cnt,
`endif
  output logic          err
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, S0, S1, S2, OUT} state_t;

  state_t        state, next_state;
  logic [2:0]    mode_r;
  logic [IW-1:0] cnt;
  logic [IW-1:0] elem;
  logic          in_run;

  // Lowest enabled stage at or above index 'from', otherwise the output phase.
  function automatic state_t stage_from(input logic [2:0] m, input logic [1:0] from);
    state_t s;
    s = OUT;
    if (m[2]) s = S2;
    if (m[1] && (from <= 2'd1)) s = S1;
    if (m[0] && (from == 2'd0)) s = S0;
    return s;
  endfunction

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = LOAD;
      LOAD:    if (in_valid && (cnt == LAST)) next_state = stage_from(mode_r, 2'd0);
      S0:      if (elem == LAST) next_state = stage_from(mode_r, 2'd1);
      S1:      if (elem == LAST) next_state = stage_from(mode_r, 2'd2);
      S2:      if (elem == LAST) next_state = OUT;
      OUT:     if (elem == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_run = (state == S0) || (state == S1) || (state == S2) || (state == OUT);

  // Loads are suppressed while reset is held so load_en reads 0 in reset.
  assign load_en = rst_n & in_valid & ((state == IDLE) || (state == LOAD));

  // Stage gates open one cycle ahead so the first processing edge is clocked.
  always_comb begin
    gate_en    = 4'b0000;
    gate_en[0] = ~cg_en | (state == S0) | (next_state == S0);
    gate_en[1] = ~cg_en | (state == S1) | (next_state == S1);
    gate_en[2] = ~cg_en | (state == S2) | (next_state == S2);
    gate_en[3] = ~cg_en | in_valid | (state == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= 3'b000;
      cnt       <= '0;
      elem      <= '0;
      err       <= 1'b0;
      stage_en  <= 3'b000;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= next_state;
      // Index counters restart on every state change; entering LOAD has already taken sample 0.
      if (state != next_state) begin
        cnt  <= (next_state == LOAD) ? IW'(1) : '0;
        elem <= '0;
      end else if ((state == LOAD) && in_valid) begin
        cnt <= cnt + IW'(1);
      end else if (in_run) begin
        elem <= elem + IW'(1);
      end
      if ((state == IDLE) && in_valid) mode_r <= in_mode;
      if (in_run && in_valid) err <= 1'b1;
      stage_en  <= {next_state == S2, next_state == S1, next_state == S0};
      out_valid <= (next_state == OUT);
      busy      <= (next_state != IDLE);
    end
  end

  assign load_idx = cnt;
  assign elem_idx = elem;

`ifdef SEQ_LAT_CNT_EN
  // Counts from the first sample until the output phase starts, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= 16'd0;
    end else if ((state == IDLE) && in_valid) begin
      lat_cnt <= 16'd0;
    end else if ((state != IDLE) && (state != OUT) && (lat_cnt != 16'hFFFF)) begin
      lat_cnt <= lat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_cg_ctrl.sv
// Bench for seq_cg_ctrl: builds each burst's expected cycle timeline from the phase rules and compares it.
module tb_seq_cg_ctrl;
  localparam int unsigned N    = 6;
  localparam int unsigned IW   = 3;
  localparam int          MAXC = 96;
  localparam int P_IDLE = 0, P_LOAD = 1, P_S0 = 2, P_OUT = 5;

  logic clk = 1'b0;
  logic rst_n, cg_en, in_valid;
  logic [2:0] in_mode;
  logic load_en, out_valid, busy, err;
  logic [IW-1:0] load_idx, elem_idx;
  logic [2:0] stage_en;
  logic [3:0] gate_en;
`ifdef SEQ_LAT_CNT_EN
  logic [15:0] lat_cnt;
`endif

  seq_cg_ctrl #(.N(N), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .cg_en(cg_en), .in_valid(in_valid), .in_mode(in_mode),
    .load_en(load_en), .load_idx(load_idx), .stage_en(stage_en), .elem_idx(elem_idx),
    .out_valid(out_valid), .gate_en(gate_en), .busy(busy),
`ifdef SEQ_LAT_CNT_EN
    .lat_cnt(lat_cnt),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit m_err;
  int ncyc, t_last;
  int ph[MAXC+1];
  bit iv[MAXC];
  // Expected and observed per-cycle traces of the most recent burst.
  logic e_busy[MAXC], e_ov[MAXC], e_len[MAXC], e_err[MAXC];
  logic [2:0] e_stage[MAXC];
  logic [IW-1:0] e_elem[MAXC], e_lidx[MAXC];
  logic [3:0] e_gate[MAXC];
  logic o_busy[MAXC], o_ov[MAXC], o_len[MAXC], o_err[MAXC];
  logic [2:0] o_stage[MAXC];
  logic [IW-1:0] o_elem[MAXC], o_lidx[MAXC];
  logic [3:0] o_gate[MAXC];
  logic [15:0] o_lat[MAXC];

  // Entered and left at posedge+1 with the DUT idle (or idle next cycle).
  task automatic run_burst(input logic [2:0] mode, input int nbub, input bit cg,
                           input int err_off, input int tail);
    int bub[N];
    int stages[$];
    int lc, pos, loaded;
    for (int j = 0; j < N; j++) bub[j] = 0;
    for (int b = 0; b < nbub; b++) bub[$urandom_range(1, N-1)]++;
    lc = 0;
    for (int j = 0; j < N; j++) begin
      for (int b = 0; b < bub[j]; b++) begin iv[lc] = 1'b0; lc++; end
      iv[lc] = 1'b1; lc++;
    end
    t_last = lc - 1;
    for (int k = 0; k < 3; k++) if (mode[k]) stages.push_back(k);
    for (int i = 0; i <= MAXC; i++) ph[i] = P_IDLE;
    for (int i = 0; i < MAXC; i++) e_elem[i] = '0;
    for (int i = 1; i < lc; i++) ph[i] = P_LOAD;
    pos = lc;
    foreach (stages[s])
      for (int c = 0; c < N; c++) begin ph[pos] = P_S0 + stages[s]; e_elem[pos] = IW'(c); pos++; end
    for (int c = 0; c < N; c++) begin ph[pos] = P_OUT; e_elem[pos] = IW'(c); pos++; end
    ncyc = pos + tail;
    for (int i = lc; i < ncyc; i++) iv[i] = (err_off >= 0) && (i == lc + err_off);
    loaded = 0;
    for (int i = 0; i < ncyc; i++) begin
      e_busy[i]  = (ph[i] != P_IDLE);
      e_ov[i]    = (ph[i] == P_OUT);
      e_stage[i] = (ph[i] >= P_S0 && ph[i] < P_OUT) ? 3'(1 << (ph[i] - P_S0)) : 3'b000;
      e_lidx[i]  = (ph[i] == P_LOAD) ? IW'(loaded) : '0;
      e_len[i]   = iv[i] && (ph[i] <= P_LOAD);
      for (int k = 0; k < 3; k++)
        e_gate[i][k] = !cg || (ph[i] == P_S0 + k) || (ph[i+1] == P_S0 + k);
      e_gate[i][3] = !cg || iv[i] || (ph[i] == P_LOAD);
      e_err[i] = m_err;
      if (iv[i] && ph[i] >= P_S0) m_err = 1'b1;
      if (e_len[i]) loaded++;
    end
    for (int i = 0; i < ncyc; i++) begin
      cg_en = cg;
      in_valid = iv[i];
      in_mode = (i == 0) ? mode : 3'($urandom);
      @(negedge clk);
      o_busy[i] = busy; o_ov[i] = out_valid; o_len[i] = load_en; o_err[i] = err;
      o_stage[i] = stage_en; o_elem[i] = elem_idx; o_lidx[i] = load_idx; o_gate[i] = gate_en;
`ifdef SEQ_LAT_CNT_EN
      o_lat[i] = lat_cnt;
`else
      o_lat[i] = 16'd0;
`endif
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    cg_en = 1'b1; in_valid = 1'b0; in_mode = 3'b000; rst_n = 1'b0;
    #3;
    checks++; if ({busy, out_valid, stage_en, load_en, err} !== 7'd0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {busy, out_valid, stage_en, load_en, err}); end
    checks++; if ({load_idx, elem_idx} !== '0) begin
      failures++; $display("FAIL reset_idx got=%h exp=0", {load_idx, elem_idx}); end
    checks++; if (gate_en !== 4'b0000) begin
      failures++; $display("FAIL reset_gate_cg1 got=%b exp=0000", gate_en); end
    cg_en = 1'b0; #1;
    checks++; if (gate_en !== 4'b1111) begin
      failures++; $display("FAIL reset_gate_cg0 got=%b exp=1111", gate_en); end
    cg_en = 1'b1; in_valid = 1'b1; #1;
    checks++; if (gate_en !== 4'b1000) begin
      failures++; $display("FAIL reset_gate_iv got=%b exp=1000", gate_en); end
    in_valid = 1'b0; m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mode101();
    int f, nov, g1;
    run_burst(3'b101, 0, 1'b1, -1, 2);
    for (int i = t_last + 1; i <= t_last + 12; i++) begin
      checks++; if (o_stage[i] !== ((i <= t_last + 6) ? 3'b001 : 3'b100)) begin
        failures++; $display("FAIL m101_stage cyc=%0d got=%b exp=%b", i, o_stage[i],
                             (i <= t_last + 6) ? 3'b001 : 3'b100); end
    end
    f = -1; nov = 0; g1 = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (o_ov[i] === 1'b1) begin nov++; if (f < 0) f = i; end
      if (o_gate[i][1] !== 1'b0) g1++;
    end
    checks++; if (f - t_last != 13) begin
      failures++; $display("FAIL m101_latency got=%0d exp=13", f - t_last); end
    checks++; if (nov != 6) begin
      failures++; $display("FAIL m101_ov_len got=%0d exp=6", nov); end
    checks++; if (g1 != 0) begin
      failures++; $display("FAIL m101_gate1 got=%0d high cycles exp=0", g1); end
    checks++; if ({o_gate[t_last-1][0], o_gate[t_last][0]} !== 2'b01) begin
      failures++; $display("FAIL m101_gate0_early got=%b exp=01", {o_gate[t_last-1][0], o_gate[t_last][0]}); end
  endtask

  task automatic test_mode000();
    int f, sn;
    run_burst(3'b000, $urandom_range(0, 2), 1'b1, -1, 1);
    f = -1; sn = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (o_ov[i] === 1'b1 && f < 0) f = i;
      if (o_stage[i] !== 3'b000) sn++;
    end
    checks++; if (f - t_last != 1) begin
      failures++; $display("FAIL m000_latency got=%0d exp=1", f - t_last); end
    checks++; if (sn != 0) begin
      failures++; $display("FAIL m000_stage got=%0d nonzero cycles exp=0", sn); end
  endtask

  task automatic test_bubbles();
    int nl, f;
    run_burst(3'b111, 2, 1'b1, -1, 1);
    nl = 0; f = -1;
    for (int i = 0; i < ncyc; i++) begin
      if (o_len[i] === 1'b1) begin
        checks++; if (o_lidx[i] !== IW'(nl)) begin
          failures++; $display("FAIL bub_load_idx cyc=%0d got=%0d exp=%0d", i, o_lidx[i], nl); end
        nl++;
      end
      if (o_ov[i] === 1'b1 && f < 0) f = i;
    end
    checks++; if (nl != 6) begin
      failures++; $display("FAIL bub_load_count got=%0d exp=6", nl); end
    checks++; if (f - t_last != 19) begin
      failures++; $display("FAIL bub_latency got=%0d exp=19", f - t_last); end
    checks++; if (o_err[ncyc-1] !== 1'b0) begin
      failures++; $display("FAIL bub_err got=%b exp=0", o_err[ncyc-1]); end
  endtask

  task automatic test_err_and_reset();
    int pc;
    run_burst(3'b111, 0, 1'b1, 8, 1);
    pc = t_last + 1 + 8;
    checks++; if ({o_err[pc], o_len[pc]} !== 2'b00) begin
      failures++; $display("FAIL err_pulse_cycle got=%b exp=00", {o_err[pc], o_len[pc]}); end
    checks++; if (o_err[ncyc-1] !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", o_err[ncyc-1]); end
    for (int i = 0; i < ncyc; i++) begin
      checks++; if ({o_stage[i], o_ov[i], o_elem[i]} !== {e_stage[i], e_ov[i], e_elem[i]}) begin
        failures++; $display("FAIL err_seq cyc=%0d got=%h exp=%h", i,
                             {o_stage[i], o_ov[i], o_elem[i]}, {e_stage[i], e_ov[i], e_elem[i]}); end
    end
    // Mode 000 burst straight into OUT, then reset two cycles into it.
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_mode = 3'b000; @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, err} !== 2'b11) begin
      failures++; $display("FAIL rst_mid_pre got=%b exp=11", {out_valid, err}); end
    rst_n = 1'b0; #1;
    checks++; if ({out_valid, busy, err, stage_en, elem_idx} !== '0) begin
      failures++; $display("FAIL rst_mid_out got=%h exp=0", {out_valid, busy, err, stage_en, elem_idx}); end
    m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random_back_to_back();
    for (int r = 0; r < 10; r++) begin
      run_burst(3'($urandom), $urandom_range(0, 3), 1'($urandom), -1, $urandom_range(0, 1));
      for (int i = 0; i < ncyc; i++) begin
        checks++;
        if ({o_busy[i], o_ov[i], o_len[i], o_err[i], o_stage[i], o_elem[i], o_lidx[i], o_gate[i]} !==
            {e_busy[i], e_ov[i], e_len[i], e_err[i], e_stage[i], e_elem[i], e_lidx[i], e_gate[i]}) begin
          failures++;
          $display("FAIL rand r=%0d cyc=%0d got bov_len_err=%b%b%b%b st=%b el=%0d li=%0d g=%b exp %b%b%b%b st=%b el=%0d li=%0d g=%b",
                   r, i, o_busy[i], o_ov[i], o_len[i], o_err[i], o_stage[i], o_elem[i], o_lidx[i], o_gate[i],
                   e_busy[i], e_ov[i], e_len[i], e_err[i], e_stage[i], e_elem[i], e_lidx[i], e_gate[i]);
        end
      end
    end
  endtask

  task automatic test_lat_cnt();
`ifdef SEQ_LAT_CNT_EN
    run_burst(3'b011, 0, 1'b1, -1, 1);
    for (int i = 0; i < ncyc; i++) begin
      if (o_ov[i] === 1'b1) begin
        checks++; if (o_lat[i] !== 16'd17) begin
          failures++; $display("FAIL lat_cnt cyc=%0d got=%0d exp=17", i, o_lat[i]); end
      end
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; cg_en = 1'b1; in_valid = 1'b0; in_mode = 3'b000; m_err = 1'b0;
    test_reset();
    test_mode101();
    test_mode000();
    test_bubbles();
    test_err_and_reset();
    test_random_back_to_back();
    test_lat_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
